// File: rtl/zpura_mem_pkg.sv
// Shared types and constants for the zpura memory arbiter.
// The FSM state encoding and port ids are fixed so that waveforms stay readable.
package zpura_mem_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_e;

  typedef enum logic {
    PORT_IF = 1'b0,
    PORT_D  = 1'b1
  } port_e;

  localparam logic [1:0] WORD_ALIGN_MASK = 2'b11;

endpackage

// File: rtl/rr_arb2.sv
// Combinational two-way round-robin pick: on contention the port that did not
// win last time is chosen, otherwise the single requester wins.
module rr_arb2
  import zpura_mem_pkg::*;
(
  input  logic [1:0] i_req,
  input  port_e      i_last,
  output logic       o_grant_valid,
  output port_e      o_grant_id
);

  always_comb begin
    o_grant_valid = |i_req;
    o_grant_id    = PORT_IF;
    if (&i_req) begin
      o_grant_id = (i_last == PORT_D) ? PORT_IF : PORT_D;
    end else if (i_req[1]) begin
      o_grant_id = PORT_D;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares memory_controller's single port between the zpura fetch and data
// ports, with alignment checking and a WAIT-state watchdog.
module mem_arbiter
  import zpura_mem_pkg::*;
#(
  parameter int TIMEOUT    = 1024,
  parameter int TO_W       = 11,
  parameter int DATA_FIRST = 1
)(
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_adr,
  output logic        if_ack,
  output logic [31:0] if_rdata,
  output logic        if_err,
  input  logic        d_req,
  input  logic        d_wren,
  input  logic [31:0] d_adr,
  input  logic [31:0] d_wdata,
  output logic        d_ack,
  output logic [31:0] d_rdata,
  output logic        d_err,
  output logic        mem_cs,
  output logic        mem_wren,
  output logic [31:0] mem_adr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_rdy,
  input  logic        mem_error,
  output logic        busy
);

  // Seeding "last" with the opposite port makes the preferred one win first.
  localparam port_e LAST_RST = (DATA_FIRST != 0) ? PORT_IF : PORT_D;

  state_e          r_state, w_state_nxt;
  port_e           r_last, w_last_nxt;
  port_e           r_gnt, w_gnt_nxt;
  port_e           w_arb_id;
  logic            w_arb_valid;
  logic            r_wren, w_wren_nxt;
  logic [31:0]     r_adr, w_adr_nxt;
  logic [31:0]     r_wdata, w_wdata_nxt;
  logic [TO_W-1:0] r_to_cnt, w_to_cnt_nxt;
  logic            w_rsp_err;
  logic [31:0]     w_rsp_rdata;
  logic            w_ack_if, w_ack_d, w_cs_nxt;

  logic            r_if_ack, r_if_err, r_d_ack, r_d_err;
  logic [31:0]     r_if_rdata, r_d_rdata;
  logic            r_mem_cs, r_mem_wren, r_busy;

  rr_arb2 u_rr_arb2 (
    .i_req         ({d_req, if_req}),
    .i_last        (r_last),
    .o_grant_valid (w_arb_valid),
    .o_grant_id    (w_arb_id)
  );

  always_comb begin
    // NOTE: every variable gets a default first so no path can infer a latch.
    w_state_nxt  = r_state;
    w_last_nxt   = r_last;
    w_gnt_nxt    = r_gnt;
    w_adr_nxt    = r_adr;
    w_wren_nxt   = r_wren;
    w_wdata_nxt  = r_wdata;
    w_to_cnt_nxt = r_to_cnt;
    w_rsp_err    = 1'b0;
    w_rsp_rdata  = '0;
    case (r_state)
      IDLE: begin
        if (w_arb_valid) begin
          w_gnt_nxt = w_arb_id;
          if (if_req && d_req) w_last_nxt = w_arb_id;
          if (w_arb_id == PORT_D) begin
            w_adr_nxt   = d_adr;
            w_wren_nxt  = d_wren;
            w_wdata_nxt = d_wdata;
          end else begin
            w_adr_nxt   = if_adr;
            w_wren_nxt  = 1'b0;
            w_wdata_nxt = '0;
          end
          if ((w_adr_nxt[1:0] & WORD_ALIGN_MASK) != 2'b00) begin
            w_state_nxt = RESP;
            w_rsp_err   = 1'b1;
          end else begin
            w_state_nxt = ISSUE;
          end
        end
      end
      ISSUE: begin
        // mem_rdy is still stale from the previous access here, so only the
        // address-fault flag is honoured.
        if (mem_error) begin
          w_state_nxt = RESP;
          w_rsp_err   = 1'b1;
        end else begin
          w_to_cnt_nxt = '0;
          w_state_nxt  = WAIT;
        end
      end
      WAIT: begin
        w_to_cnt_nxt = r_to_cnt + TO_W'(1);
        if (mem_rdy) begin
          w_state_nxt = RESP;
          w_rsp_rdata = r_wren ? 32'h0 : mem_rdata;
        end else if (r_to_cnt == TO_W'(TIMEOUT - 1)) begin
          w_state_nxt = RESP;
          w_rsp_err   = 1'b1;
        end
      end
      RESP:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase

    w_ack_if = (w_state_nxt == RESP) && (w_gnt_nxt == PORT_IF);
    w_ack_d  = (w_state_nxt == RESP) && (w_gnt_nxt == PORT_D);
    w_cs_nxt = (w_state_nxt == ISSUE) || (w_state_nxt == WAIT);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  // NOTE: the latched request registers are reset too, because they drive
  // mem_adr/mem_wdata directly and every output must read 0 in reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= IDLE;
      r_last     <= LAST_RST;
      r_gnt      <= PORT_IF;
      r_wren     <= 1'b0;
      r_adr      <= '0;
      r_wdata    <= '0;
      r_to_cnt   <= '0;
      r_if_ack   <= 1'b0;
      r_if_rdata <= '0;
      r_if_err   <= 1'b0;
      r_d_ack    <= 1'b0;
      r_d_rdata  <= '0;
      r_d_err    <= 1'b0;
      r_mem_cs   <= 1'b0;
      r_mem_wren <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_last     <= w_last_nxt;
      r_gnt      <= w_gnt_nxt;
      r_wren     <= w_wren_nxt;
      r_adr      <= w_adr_nxt;
      r_wdata    <= w_wdata_nxt;
      r_to_cnt   <= w_to_cnt_nxt;
      r_if_ack   <= w_ack_if;
      r_if_rdata <= w_ack_if ? w_rsp_rdata : 32'h0;
      r_if_err   <= w_ack_if & w_rsp_err;
      r_d_ack    <= w_ack_d;
      r_d_rdata  <= w_ack_d ? w_rsp_rdata : 32'h0;
      r_d_err    <= w_ack_d & w_rsp_err;
      r_mem_cs   <= w_cs_nxt;
      r_mem_wren <= w_cs_nxt & w_wren_nxt;
      r_busy     <= (w_state_nxt != IDLE);
    end
  end

  assign if_ack    = r_if_ack;
  assign if_rdata  = r_if_rdata;
  assign if_err    = r_if_err;
  assign d_ack     = r_d_ack;
  assign d_rdata   = r_d_rdata;
  assign d_err     = r_d_err;
  assign mem_cs    = r_mem_cs;
  assign mem_wren  = r_mem_wren;
  assign mem_adr   = r_adr;
  assign mem_wdata = r_wdata;
  assign busy      = r_busy;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: stimulus queues expected responses, a
// monitor checks the memory bus every cycle and each ack against the queue.
module tb_mem_arbiter;
  import zpura_mem_pkg::*;

  logic        clk, rst;
  logic        if_req, if_ack, if_err;
  logic [31:0] if_adr, if_rdata;
  logic        d_req, d_wren, d_ack, d_err;
  logic [31:0] d_adr, d_wdata, d_rdata;
  logic        mem_cs, mem_wren, mem_rdy, mem_error, busy;
  logic [31:0] mem_adr, mem_wdata, mem_rdata;

  typedef struct {
    port_e       port;
    logic [31:0] adr;
    logic        wren;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;
    int          cs_cyc;
    int          busy_cyc;
  } exp_t;

  exp_t        exp_q[$];
  int          n_checks = 0;
  int          n_errors = 0;
  int          mdl_lat = 1;
  logic        mdl_err = 1'b0;
  logic [31:0] mdl_rdata = 32'h0;

  mem_arbiter #(.TIMEOUT(8), .TO_W(4), .DATA_FIRST(1)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_adr(if_adr), .if_ack(if_ack), .if_rdata(if_rdata), .if_err(if_err),
    .d_req(d_req), .d_wren(d_wren), .d_adr(d_adr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata), .d_err(d_err),
    .mem_cs(mem_cs), .mem_wren(mem_wren), .mem_adr(mem_adr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_rdy(mem_rdy), .mem_error(mem_error), .busy(busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Memory model: mem_error in the ISSUE cycle if asked, mem_rdy with data in
  // the mdl_lat-th WAIT cycle (mdl_lat = 0 means never ready).
  initial begin : mem_model
    int cnt = 0;
    mem_rdy = 1'b0; mem_error = 1'b0; mem_rdata = 32'h0;
    forever begin
      @(negedge clk);
      if (!rst || !mem_cs) cnt = 0;
      else cnt++;
      mem_error = (cnt == 1) && mdl_err;
      mem_rdy   = (mdl_lat > 0) && (cnt == 1 + mdl_lat);
      mem_rdata = mem_rdy ? mdl_rdata : 32'h0;
    end
  end

  initial begin : monitor
    int   cs_cnt = 0;
    int   busy_cnt = 0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        cs_cnt = 0;
        busy_cnt = 0;
      end else begin
        if (mem_cs) begin
          cs_cnt++;
          if (exp_q.size() == 0) begin
            n_checks++; n_errors++;
            $display("FAIL cs_unexpected: mem_cs=1 expected no access");
          end else begin
            check("mem_adr", mem_adr, exp_q[0].adr);
            check("mem_wren", mem_wren, exp_q[0].wren);
            if (exp_q[0].wren) check("mem_wdata", mem_wdata, exp_q[0].wdata);
          end
        end else begin
          check("mem_wren_idle", mem_wren, 0);
        end
        if (busy) busy_cnt++;
        if (!if_ack) begin
          check("if_rdata_quiet", if_rdata, 0);
          check("if_err_quiet", if_err, 0);
        end
        if (!d_ack) begin
          check("d_rdata_quiet", d_rdata, 0);
          check("d_err_quiet", d_err, 0);
        end
        if (if_ack && d_ack) begin
          n_checks++; n_errors++;
          $display("FAIL double_ack: if_ack=1 d_ack=1 expected one");
          cs_cnt = 0; busy_cnt = 0;
        end else if (if_ack || d_ack) begin
          if (if_ack) check("if_ack_req", if_req, 1);
          if (d_ack)  check("d_ack_req", d_req, 1);
          if (exp_q.size() == 0) begin
            n_checks++; n_errors++;
            $display("FAIL ack_unexpected: ack seen with no pending access");
          end else begin
            e = exp_q.pop_front();
            check("ack_port", d_ack, e.port == PORT_D);
            check("ack_rdata", d_ack ? d_rdata : if_rdata, e.rdata);
            check("ack_err", d_ack ? d_err : if_err, e.err);
            check("cs_cycles", cs_cnt, e.cs_cyc);
            check("busy_cycles", busy_cnt, e.busy_cyc);
          end
          cs_cnt = 0; busy_cnt = 0;
        end
      end
    end
  end

  task automatic push(input port_e p, input logic [31:0] adr, input logic wren,
                      input logic [31:0] wdata, input logic [31:0] rdata, input logic err,
                      input int cs_cyc, input int busy_cyc);
    exp_t e;
    e.port = p; e.adr = adr; e.wren = wren; e.wdata = wdata;
    e.rdata = rdata; e.err = err; e.cs_cyc = cs_cyc; e.busy_cyc = busy_cyc;
    exp_q.push_back(e);
  endtask

  task automatic drive_port(input port_e p, input logic [31:0] adr, input logic wren,
                            input logic [31:0] wdata);
    if (p == PORT_D) begin
      d_adr = adr; d_wren = wren; d_wdata = wdata; d_req = 1'b1;
    end else begin
      if_adr = adr; if_req = 1'b1;
    end
  endtask

  // One access on one port; ack must arrive exactly busy_cyc cycles after req.
  task automatic run_single(input port_e p, input logic [31:0] adr, input logic wren,
                            input logic [31:0] wdata, input int lat, input logic merr,
                            input logic [31:0] mrdata, input logic [31:0] exp_rdata,
                            input logic exp_err, input int cs_cyc, input int busy_cyc);
    int   waited = 0;
    logic got = 1'b0;
    mdl_lat = lat; mdl_err = merr; mdl_rdata = mrdata;
    push(p, adr, (p == PORT_D) && wren, wdata, exp_rdata, exp_err, cs_cyc, busy_cyc);
    @(negedge clk); #1;
    drive_port(p, adr, wren, wdata);
    while (!got && waited < 50) begin
      @(negedge clk);
      waited++;
      got = (p == PORT_D) ? d_ack : if_ack;
    end
    if (!got) begin
      n_checks++; n_errors++;
      $display("FAIL ack_timeout: no ack after %0d cycles expected %0d", waited, busy_cyc);
      exp_q.delete();
    end else begin
      check("ack_latency", waited, busy_cyc);
    end
    #1;
    if_req = 1'b0; d_req = 1'b0; d_wren = 1'b0;
    @(negedge clk);
  endtask

  // Both ports request together and keep requesting until n_d / n_if acks.
  task automatic run_pair(input int n_d, input int n_if);
    int cnt_d = 0;
    int cnt_if = 0;
    int waited = 0;
    @(negedge clk); #1;
    d_req = 1'b1; if_req = 1'b1;
    while ((d_req || if_req) && waited < 200) begin
      @(negedge clk);
      waited++;
      if (d_ack)  cnt_d++;
      if (if_ack) cnt_if++;
      #1;
      if (cnt_d >= n_d)   d_req = 1'b0;
      if (cnt_if >= n_if) if_req = 1'b0;
    end
    if (d_req || if_req) begin
      n_checks++; n_errors++;
      $display("FAIL pair_timeout: acks d=%0d if=%0d expected %0d/%0d", cnt_d, cnt_if, n_d, n_if);
      d_req = 1'b0; if_req = 1'b0;
      exp_q.delete();
    end
    d_wren = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b0;
    if_req = 1'b0; if_adr = 32'h0;
    d_req = 1'b0; d_wren = 1'b0; d_adr = 32'h0; d_wdata = 32'h0;
    @(negedge clk); @(negedge clk);
    check("rst_if_ack", if_ack, 0);
    check("rst_d_ack", d_ack, 0);
    check("rst_mem_cs", mem_cs, 0);
    check("rst_busy", busy, 0);
    check("rst_mem_adr", mem_adr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    #1 rst = 1'b1;

    // port, adr, wren, wdata, lat, merr, mrdata, exp_rdata, exp_err, cs, busy
    run_single(PORT_IF, 32'h0000_0100, 1'b0, 32'h0,          3, 1'b0, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, 4, 5);
    run_single(PORT_D,  32'h0000_0010, 1'b1, 32'h1234_5678,  2, 1'b0, 32'hFFFF_0000, 32'h0,         1'b0, 3, 4);
    run_single(PORT_D,  32'h0000_0040, 1'b0, 32'h0,          1, 1'b0, 32'h5555_AAAA, 32'h5555_AAAA, 1'b0, 2, 3);
    run_single(PORT_D,  32'h0000_0102, 1'b0, 32'h0,          1, 1'b0, 32'h1111_1111, 32'h0,         1'b1, 0, 1);
    run_single(PORT_IF, 32'h0000_0103, 1'b0, 32'h0,          1, 1'b0, 32'h2222_2222, 32'h0,         1'b1, 0, 1);
    run_single(PORT_D,  32'h0000_0011, 1'b1, 32'hABCD_0000,  1, 1'b0, 32'h0,         32'h0,         1'b1, 0, 1);
    run_single(PORT_IF, 32'h0000_0200, 1'b0, 32'h0,          1, 1'b1, 32'h3333_3333, 32'h0,         1'b1, 1, 2);
    run_single(PORT_D,  32'h0000_0404, 1'b0, 32'h0,          0, 1'b0, 32'h4444_4444, 32'h0,         1'b1, 9, 10);
    run_single(PORT_IF, 32'h0000_0400, 1'b0, 32'h0,          8, 1'b0, 32'h8888_1111, 32'h8888_1111, 1'b0, 9, 10);

    // Contention: data wins first (DATA_FIRST), then strict alternation.
    mdl_lat = 1; mdl_err = 1'b0; mdl_rdata = 32'h0BAD_F00D;
    if_adr = 32'h0000_0300; d_adr = 32'h0000_0020; d_wren = 1'b1; d_wdata = 32'hCAFE_0001;
    push(PORT_D,  32'h0000_0020, 1'b1, 32'hCAFE_0001, 32'h0,         1'b0, 2, 3);
    push(PORT_IF, 32'h0000_0300, 1'b0, 32'h0,         32'h0BAD_F00D, 1'b0, 2, 3);
    push(PORT_D,  32'h0000_0020, 1'b1, 32'hCAFE_0001, 32'h0,         1'b0, 2, 3);
    push(PORT_IF, 32'h0000_0300, 1'b0, 32'h0,         32'h0BAD_F00D, 1'b0, 2, 3);
    run_pair(2, 2);
    check("pair_drained", exp_q.size(), 0);

    // Reset in the middle of WAIT.
    mdl_lat = 0;
    push(PORT_D, 32'h0000_0500, 1'b0, 32'h0, 32'h0, 1'b0, 0, 0);
    @(negedge clk); #1;
    drive_port(PORT_D, 32'h0000_0500, 1'b0, 32'h0);
    repeat (4) @(negedge clk);
    check("cs_before_reset", mem_cs, 1);
    #2 rst = 1'b0;
    #1;
    check("rst_mid_mem_cs", mem_cs, 0);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_d_ack", d_ack, 0);
    check("rst_mid_if_ack", if_ack, 0);
    exp_q.delete();
    d_req = 1'b0;
    @(negedge clk); @(negedge clk);
    #1 rst = 1'b1;

    mdl_lat = 1; mdl_rdata = 32'h6060_6060;
    if_adr = 32'h0000_0604; d_adr = 32'h0000_0600; d_wren = 1'b1; d_wdata = 32'h0000_0077;
    push(PORT_D,  32'h0000_0600, 1'b1, 32'h0000_0077, 32'h0,         1'b0, 2, 3);
    push(PORT_IF, 32'h0000_0604, 1'b0, 32'h0,         32'h6060_6060, 1'b0, 2, 3);
    run_pair(1, 1);
    check("post_reset_drained", exp_q.size(), 0);

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-requester arbiter and sequencer in front of memory_controller's single port.
- Shares the port between the zpura instruction-fetch port (read-only) and the data port (read/write).
- Runs each access as a cs/rdy transaction and returns read data or error to the winning requester.
- Adds three checks of its own: round-robin fairness, word-alignment checking and a watchdog timeout that ends accesses that never complete.

Parameters:
- TIMEOUT, 1024, max cycles in WAIT before the access is aborted with an error; must be >= 2.
- TO_W, 11, width of the timeout counter; must satisfy 2^TO_W > TIMEOUT.
- DATA_FIRST, 1, on a simultaneous request straight after reset, 1 grants the data port first and 0 grants fetch first.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- rst  in  1  reset, asynchronous and active-low; 0 resets the block.
- if_req  in  1  fetch request; held high, with if_adr stable, until if_ack.
- if_adr  in  32  fetch byte address.
- if_ack  out  1  one-cycle completion pulse to the fetch port.
- if_rdata  out  32  read data; valid only in the if_ack cycle.
- if_err  out  1  error flag; valid only in the if_ack cycle.
- d_req  in  1  data request; held high, with d_adr/d_wren/d_wdata stable, until d_ack.
- d_wren  in  1  1 = write, 0 = read.
- d_adr  in  32  data byte address.
- d_wdata  in  32  write data.
- d_ack  out  1  one-cycle completion pulse to the data port.
- d_rdata  out  32  read data; valid only in the d_ack cycle.
- d_err  out  1  error flag; valid only in the d_ack cycle.
- mem_cs  out  1  chip select to the memory controller.
- mem_wren  out  1  write enable to the memory controller.
- mem_adr  out  32  byte address to the memory controller.
- mem_wdata  out  32  write data to the memory controller; the top level resolves the bidirectional data bus.
- mem_rdata  in  32  read data from the memory controller.
- mem_rdy  in  1  transfer-complete flag from the memory controller.
- mem_error  in  1  address-fault flag from the memory controller.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE; every output 0.
  - Last-grant register = fetch if DATA_FIRST=1, else data.
  - Timeout counter = 0.
  - Reset mid-transaction drops mem_cs immediately; no ack is issued.
- States: IDLE, ISSUE, WAIT, RESP. All outputs are registered.
- IDLE:
  - No request: stay in IDLE.
  - Exactly one request: grant it.
  - Both requests: grant the port that was NOT granted last, then update the last-grant register.
  - On grant, latch address, wren and wdata into internal registers.
  - If the latched address has bits [1:0] != 0: go to RESP with err=1; mem_cs is never asserted.
  - Otherwise go to ISSUE.
  - The fetch port always issues with mem_wren=0.
- ISSUE (exactly 1 cycle):
  - mem_cs=1, with mem_adr/mem_wren/mem_wdata from the latched registers.
  - If mem_error=1 this cycle: err=1, go to RESP.
  - Otherwise clear the timeout counter and go to WAIT.
  - mem_rdy is ignored in ISSUE, because the controller's rdy level is stale for one cycle.
- WAIT:
  - mem_cs stays 1 and the latched mem_* values stay stable; the counter increments every cycle.
  - mem_rdy=1: capture mem_rdata (reads only), err=0, go to RESP.
  - Otherwise, if counter == TIMEOUT-1: err=1, go to RESP. The abort therefore happens after exactly TIMEOUT WAIT cycles.
  - If mem_rdy=1 and the timeout fire in the same cycle, mem_rdy wins and err=0.
- RESP (1 cycle):
  - mem_cs=0; mem_wren=0.
  - Pulse the granted port's ack with its rdata and err; the other port's ack, rdata and err stay 0.
  - rdata is 0 on writes and on errors.
  - Go to IDLE.
- Latency:
  - Request seen in IDLE at cycle N gives ISSUE at N+1, WAIT from N+2, and ack one cycle after mem_rdy is sampled high in WAIT.
  - Best case (mem_rdy high in the first WAIT cycle, N+2): ack at N+3.
  - Misaligned address: ack at N+1.
- Requester rule: drop req in the cycle after ack. A req still high in the next IDLE cycle starts a new access.
- Requests are never granted while busy=1. No queueing: req is a level, not a pulse.

Decomposition:
- Package zpura_mem_pkg holds:
  - Typedef for the state enum: IDLE=2'd0, ISSUE=2'd1, WAIT=2'd2, RESP=2'd3.
  - Port-id typedef: PORT_IF=1'b0, PORT_D=1'b1.
  - Constant WORD_ALIGN_MASK=2'b11.
- One sub-module: rr_arb2. It is a combinational 2-way round-robin pick from {req[1:0], last} to {grant_valid, grant_id}.
- The sequencing FSM and datapath stay in mem_arbiter.

Test Plan:
1. Fetch read: if_req=1, if_adr=32'h0000_0100; memory model gives mem_rdy high in the 3rd WAIT cycle with rdata=32'hDEAD_BEEF -> if_ack one cycle later, if_rdata=32'hDEAD_BEEF, if_err=0, mem_wren=0 throughout.
2. Data write: d_wren=1, d_adr=32'h10, d_wdata=32'h1234_5678 -> mem_cs high from ISSUE until mem_rdy, mem_wdata=32'h1234_5678, d_ack with d_err=0, d_rdata=0.
3. Contention: both req held for 4 back-to-back transactions with DATA_FIRST=1 -> grant order D, IF, D, IF; no ack ever goes to a non-requesting port.
4. Faults:
   - d_adr=32'h0000_0102 -> d_ack at N+1, d_err=1, mem_cs never asserted.
   - mem_error=1 in ISSUE -> ack with err=1 in the next cycle.
5. Timeout: TIMEOUT=8, mem_rdy stuck at 0 -> mem_cs high for 1+8 cycles, then ack with err=1; mem_rdy=1 exactly in the 8th WAIT cycle -> err=0.
6. Reset: assert rst=0 asynchronously in the middle of WAIT -> mem_cs, busy and all acks go 0 immediately. After release, a simultaneous request is granted to the data port first (DATA_FIRST=1).
